// File: rtl/aeu_pkg.sv
// Shared types and widths for the arithmetic execute unit.
// Optional flag output is enabled with the AEU_FLAGS_EN macro.
package aeu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned OPW   = 5;
  localparam int unsigned HWW   = 6;
  localparam int unsigned HALFW = 16;

  typedef enum logic [OPW-1:0] {
    OP_PLUS   = 5'd0,
    OP_MINUS  = 5'd1,
    OP_ORN    = 5'd2,
    OP_OR     = 5'd3,
    OP_EOR    = 5'd4,
    OP_AND    = 5'd5,
    OP_MOVK   = 5'd6,
    OP_MOVZ   = 5'd7,
    OP_LSL    = 5'd8,
    OP_LSR    = 5'd9,
    OP_ASR    = 5'd10,
    OP_PASS_A = 5'd11,
    OP_CSNEG  = 5'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2
  } shift_mode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/aeu_shifter.sv
// Combinational barrel shifter plus 16-bit halfword placement and mask
// generation used by the MOVZ/MOVK ops.
module aeu_shifter
  import aeu_pkg::*;
(
  input  logic [XLEN-1:0]  data_i,
  input  logic [HALFW-1:0] half_i,
  input  logic [HWW-1:0]   amt_i,
  input  shift_mode_t      mode_i,
  output logic [XLEN-1:0]  shifted_c_o,
  output logic [XLEN-1:0]  placed_c_o,
  output logic [XLEN-1:0]  mask_c_o
);

  always_comb begin
    shifted_c_o = '0;
    case (mode_i)
      SH_LSL:  shifted_c_o = data_i << amt_i;
      SH_LSR:  shifted_c_o = data_i >> amt_i;
      SH_ASR:  shifted_c_o = XLEN'($signed(data_i) >>> amt_i);
      default: shifted_c_o = '0;
    endcase
  end

  // Non-aligned amounts are applied as raw bit shifts.
  assign placed_c_o = XLEN'(half_i) << amt_i;
  assign mask_c_o   = XLEN'({HALFW{1'b1}}) << amt_i;

endmodule

// File: rtl/arithmetic_execute_unit.sv
// Single-cycle 64-bit integer ALU execute stage with registered result and done strobe.
// Define AEU_FLAGS_EN to add the registered nzcv flag output.
module arithmetic_execute_unit
  import aeu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OPW-1:0]  ALUop,
  input  logic [XLEN-1:0] alu_vala,
  input  logic [XLEN-1:0] alu_valb,
  input  logic [HWW-1:0]  alu_valhw,
  output logic [XLEN-1:0] res,
  output logic            done
`ifdef AEU_FLAGS_EN
  ,
  output nzcv_t           nzcv
`endif
);

  alu_op_t         op;
  shift_mode_t     sh_mode;
  logic [XLEN-1:0] shifted_c;
  logic [XLEN-1:0] placed_c;
  logic [XLEN-1:0] mask_c;
  logic [XLEN-1:0] neg_b_c;
  logic [XLEN-1:0] result_c;
  logic [XLEN-1:0] res_d, res_q;
  logic            done_d, done_q;

  assign op      = alu_op_t'(ALUop);
  assign neg_b_c = (~alu_valb) + XLEN'(1);

  // Add/subtract carry one extra bit only when the flags need it.
`ifdef AEU_FLAGS_EN
  logic [XLEN:0] sum_c;
  logic [XLEN:0] diff_c;
  assign sum_c  = {1'b0, alu_vala} + {1'b0, alu_valb};
  assign diff_c = {1'b0, alu_vala} - {1'b0, alu_valb};
`else
  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] diff_c;
  assign sum_c  = alu_vala + alu_valb;
  assign diff_c = alu_vala - alu_valb;
`endif

  always_comb begin
    sh_mode = SH_LSL;
    case (op)
      OP_LSR:  sh_mode = SH_LSR;
      OP_ASR:  sh_mode = SH_ASR;
      default: sh_mode = SH_LSL;
    endcase
  end

  aeu_shifter u_shifter (
    .data_i      (alu_vala),
    .half_i      (alu_valb[HALFW-1:0]),
    .amt_i       (alu_valhw),
    .mode_i      (sh_mode),
    .shifted_c_o (shifted_c),
    .placed_c_o  (placed_c),
    .mask_c_o    (mask_c)
  );

  // Op decode; undefined encodings yield zero.
  always_comb begin
    result_c = '0;
    case (op)
      OP_PLUS:                result_c = sum_c[XLEN-1:0];
      OP_MINUS:               result_c = diff_c[XLEN-1:0];
      OP_ORN:                 result_c = alu_vala | ~alu_valb;
      OP_OR:                  result_c = alu_vala | alu_valb;
      OP_EOR:                 result_c = alu_vala ^ alu_valb;
      OP_AND:                 result_c = alu_vala & alu_valb;
      OP_MOVK:                result_c = (alu_vala & ~mask_c) | placed_c;
      OP_MOVZ:                result_c = placed_c;
      OP_LSL, OP_LSR, OP_ASR: result_c = shifted_c;
      OP_PASS_A:              result_c = alu_vala;
      OP_CSNEG:               result_c = (alu_vala == '0) ? alu_valb : neg_b_c;
      default:                result_c = '0;
    endcase
  end

  always_comb begin
    res_d  = res_q;
    done_d = start;
    if (start) begin
      res_d = result_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign res  = res_q;
  assign done = done_q;

`ifdef AEU_FLAGS_EN
  nzcv_t nzcv_d, nzcv_q;

  // C is carry-out for add and not-borrow for subtract.
  always_comb begin
    nzcv_d = nzcv_q;
    if (start) begin
      nzcv_d.n = result_c[XLEN-1];
      nzcv_d.z = (result_c == '0);
      nzcv_d.c = 1'b0;
      nzcv_d.v = 1'b0;
      case (op)
        OP_PLUS: begin
          nzcv_d.c = sum_c[XLEN];
          nzcv_d.v = (alu_vala[XLEN-1] == alu_valb[XLEN-1]) &&
                     (result_c[XLEN-1] != alu_vala[XLEN-1]);
        end
        OP_MINUS: begin
          nzcv_d.c = ~diff_c[XLEN];
          nzcv_d.v = (alu_vala[XLEN-1] != alu_valb[XLEN-1]) &&
                     (result_c[XLEN-1] != alu_vala[XLEN-1]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzcv_q <= '0;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign nzcv = nzcv_q;
`endif

endmodule

// File: tb/tb_arithmetic_execute_unit.sv
// Scoreboard bench for arithmetic_execute_unit: driver queues expected results,
// a monitor pops and compares on every done pulse. Flags are checked with AEU_FLAGS_EN.
module tb_arithmetic_execute_unit;
  import aeu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ALUop;
  logic [63:0] alu_vala;
  logic [63:0] alu_valb;
  logic [5:0]  alu_valhw;
  logic [63:0] res;
  logic        done;
`ifdef AEU_FLAGS_EN
  nzcv_t       nzcv;
`endif

  arithmetic_execute_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ALUop     (ALUop),
    .alu_vala  (alu_vala),
    .alu_valb  (alu_valb),
    .alu_valhw (alu_valhw),
    .res       (res),
    .done      (done)
`ifdef AEU_FLAGS_EN
    ,
    .nzcv      (nzcv)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   done_cnt = 0;
  int   issued   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && done === 1'b1) begin
        exp_t e;
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL spurious_done: done=1 with nothing pending, res=%h", res);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_res"}, res, e.res);
`ifdef AEU_FLAGS_EN
          check({e.name, "_nzcv"}, 64'(nzcv), 64'(e.nzcv));
`endif
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] hw,
                       input logic [63:0] er, input logic [3:0] ef);
    exp_t e;
    start     = 1'b1;
    ALUop     = op;
    alu_vala  = a;
    alu_valb  = b;
    alu_valhw = hw;
    e.name = nm;
    e.res  = er;
    e.nzcv = ef;
    sb_q.push_back(e);
    issued++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; ALUop = '0;
    alu_vala = '0; alu_valb = '0; alu_valhw = '0;
    repeat (2) @(negedge clk);
    check("reset_res", res, 64'h0);
    check("reset_done", 64'(done), 64'h0);
    rst = 1'b1;
    idle(2);
    check("idle_res", res, 64'h0);
    check("idle_done", 64'(done), 64'h0);

    issue("plus_1_1", OP_PLUS, 64'h1, 64'h1, 6'd0, 64'h2, 4'b0000);
    idle(2);
    issue("minus_0_1", OP_MINUS, 64'h0, 64'h1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    idle(1);
    issue("movz", OP_MOVZ, 64'h0, 64'hBEEF, 6'd32, 64'h0000_BEEF_0000_0000, 4'b0000);
    issue("movk", OP_MOVK, 64'h1111_2222_3333_4444, 64'hABCD, 6'd16,
          64'h1111_2222_ABCD_4444, 4'b0000);
    issue("asr_63", OP_ASR, 64'h8000_0000_0000_0000, 64'h0, 6'd63,
          64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    issue("lsr_63", OP_LSR, 64'h8000_0000_0000_0000, 64'h0, 6'd63, 64'h1, 4'b0000);
    issue("undef_31", 5'd31, 64'h1234, 64'h5678, 6'd3, 64'h0, 4'b0100);
    issue("lsl_0", OP_LSL, 64'h1234, 64'h0, 6'd0, 64'h1234, 4'b0000);
    issue("lsl_63", OP_LSL, 64'h1, 64'h0, 6'd63, 64'h8000_0000_0000_0000, 4'b1000);
    issue("plus_wrap", OP_PLUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 6'd0, 64'h0, 4'b0110);
    issue("plus_ovf", OP_PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 6'd0,
          64'h8000_0000_0000_0000, 4'b1001);
    issue("minus_eq", OP_MINUS, 64'h5, 64'h5, 6'd0, 64'h0, 4'b0110);
    issue("orn", OP_ORN, 64'hF0, 64'hFFFF_FFFF_FFFF_FFF0, 6'd0, 64'hFF, 4'b0000);
    issue("or", OP_OR, 64'hF0, 64'h0F, 6'd0, 64'hFF, 4'b0000);
    issue("eor", OP_EOR, 64'hFF, 64'h0F, 6'd0, 64'hF0, 4'b0000);
    issue("pass_a", OP_PASS_A, 64'hDEAD_BEEF_0000_0001, 64'h7, 6'd5,
          64'hDEAD_BEEF_0000_0001, 4'b1000);
    issue("csneg_zero", OP_CSNEG, 64'h0, 64'h5, 6'd0, 64'h5, 4'b0000);
    issue("csneg_neg", OP_CSNEG, 64'h1, 64'h5, 6'd0, 64'hFFFF_FFFF_FFFF_FFFB, 4'b1000);
    idle(2);

    issue("b2b_plus", OP_PLUS, 64'h2, 64'h3, 6'd0, 64'h5, 4'b0000);
    issue("b2b_and", OP_AND, 64'hF0, 64'h3C, 6'd0, 64'h30, 4'b0000);
    idle(2);
    check("hold_res", res, 64'h30);

    // Reset lands after the accepting edge: the result must vanish at once.
    start = 1'b1; ALUop = OP_PLUS; alu_vala = 64'h7; alu_valb = 64'h8; alu_valhw = '0;
    @(posedge clk);
    #2;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_res", res, 64'h0);
    check("midrst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("postrst_res", res, 64'h0);

    issue("after_rst", OP_PLUS, 64'h10, 64'h20, 6'd0, 64'h30, 4'b0000);
    idle(3);
    check("queue_drained", 64'(sb_q.size()), 64'h0);
    check("done_pulses", 64'(done_cnt), 64'(issued));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
